// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared register size, divider FSM encoding and address-match helper
package hazard_ctrl_pkg;
    localparam int REG_SIZE = 5;
    localparam int DIV_CYCLES_DEF = 32;
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } divState_t;
    function automatic logic regHit(input logic [REG_SIZE-1:0] dst, input logic [REG_SIZE-1:0] a, input logic [REG_SIZE-1:0] b);
        return (dst != '0) && ((dst == a) || (dst == b));
    endfunction
endpackage

// File: rtl/hazard_ctrl_div_seq.sv
// hazard_ctrl_div_seq: divider start/latency/done sequencer holding the pipeline while busy
module hazard_ctrl_div_seq
    import hazard_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic divE,
    output logic divStall,
    output logic divStart,
    output logic divDone
);
    divState_t state, nextState;
    logic [CNT_W-1:0] cnt, nextCnt;
    // state and latency counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
            cnt <= '0;
        end else begin
            state <= nextState;
            cnt <= nextCnt;
        end
    end
    // next state, counter and strobes; everything is silenced while in reset
    always_comb begin
        nextState = state;
        nextCnt = cnt;
        divStart = 1'b0;
        divStall = 1'b0;
        divDone = 1'b0;
        case (state)
            DIV_IDLE: if (divE) begin
                divStart = 1'b1;
                divStall = 1'b1;
                nextState = DIV_BUSY;
                nextCnt = CNT_W'(DIV_CYCLES - 1);
            end
            DIV_BUSY: begin
                divStall = 1'b1;
                if (cnt == '0) nextState = DIV_DONE;
                else nextCnt = cnt - 1'b1;
            end
            DIV_DONE: begin
                divDone = 1'b1;
                nextState = DIV_IDLE;
            end
            default: nextState = DIV_IDLE;
        endcase
        if (rst) begin
            divStart = 1'b0;
            divStall = 1'b0;
            divDone = 1'b0;
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use/branch hazard stalls and divider hold; HAZARD_STATS_EN adds stall/divide counters
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic [REG_SIZE-1:0] rsD,
    input  logic [REG_SIZE-1:0] rtD,
    input  logic [REG_SIZE-1:0] rtE,
    input  logic [REG_SIZE-1:0] writeRegAddrE,
    input  logic [REG_SIZE-1:0] writeRegAddrM,
    input  logic Regfile_weE,
    input  logic memtoRegE,
    input  logic memtoRegM,
    input  logic branchD,
    input  logic divE,
    output logic stallF,
    output logic stallD,
    output logic stallE,
    output logic flushE,
    output logic flushM,
    output logic div_start,
    output logic div_busy,
`ifdef HAZARD_STATS_EN
    output logic [31:0] stall_cycles,
    output logic [15:0] div_count,
`endif
    output logic div_done
);
    logic lwStall, brStall, divStall, hzStall;
    hazard_ctrl_div_seq #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) divSeq (
        .clk(clk),
        .rst(rst),
        .divE(divE),
        .divStall(divStall),
        .divStart(div_start),
        .divDone(div_done)
    );
    // hazard terms and output muxing; divider hold wins over the ID/EX bubble
    always_comb begin
        lwStall = memtoRegE && regHit(rtE, rsD, rtD);
        brStall = branchD && ((Regfile_weE && regHit(writeRegAddrE, rsD, rtD)) || (memtoRegM && regHit(writeRegAddrM, rsD, rtD)));
        hzStall = !rst && (lwStall || brStall);
        stallF = hzStall || divStall;
        stallD = stallF;
        stallE = divStall;
        flushM = divStall;
        div_busy = divStall;
        flushE = hzStall && !divStall;
    end
`ifdef HAZARD_STATS_EN
    // saturating stall-cycle counter and wrapping divide counter
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            div_count <= '0;
        end else begin
            if (stallF && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
            if (div_done) div_count <= div_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl with DIV_CYCLES=4
module tb_hazard_ctrl;
    localparam int DC = 4;
    logic clk = 1'b0;
    logic rst;
    logic [4:0] rsD, rtD, rtE, writeRegAddrE, writeRegAddrM;
    logic Regfile_weE, memtoRegE, memtoRegM, branchD, divE;
    logic stallF, stallD, stallE, flushE, flushM, div_start, div_busy, div_done;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [15:0] div_count;
`endif
    int nChecks = 0;
    int nPass = 0;
    logic [7:0] expQ[$];
    int busyLeft = 0;
    bit doneNow = 0;
    int cyc = 0;
    bit trackDone = 0;
    int doneCyc[$];

    hazard_ctrl #(.DIV_CYCLES(DC), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rtE(rtE),
        .writeRegAddrE(writeRegAddrE), .writeRegAddrM(writeRegAddrM),
        .Regfile_weE(Regfile_weE), .memtoRegE(memtoRegE), .memtoRegM(memtoRegM),
        .branchD(branchD), .divE(divE), .stallF(stallF), .stallD(stallD),
        .stallE(stallE), .flushE(flushE), .flushM(flushM), .div_start(div_start),
        .div_busy(div_busy),
`ifdef HAZARD_STATS_EN
        .stall_cycles(stall_cycles), .div_count(div_count),
`endif
        .div_done(div_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic bit hit(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
        return d != 0 && (d == a || d == b);
    endfunction

    task automatic step(input string tag, input logic r, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] re, input logic [4:0] wa, input logic [4:0] wm,
                        input logic we, input logic me, input logic mm, input logic br, input logic dv);
        bit lw, bs, ds, idle;
        logic [7:0] e;
        @(negedge clk);
        rst = r; rsD = rs; rtD = rt; rtE = re; writeRegAddrE = wa; writeRegAddrM = wm;
        Regfile_weE = we; memtoRegE = me; memtoRegM = mm; branchD = br; divE = dv;
        lw = me && hit(re, rs, rt);
        bs = br && ((we && hit(wa, rs, rt)) || (mm && hit(wm, rs, rt)));
        idle = busyLeft == 0 && !doneNow;
        ds = (idle && dv) || busyLeft > 0;
        e = r ? 8'h00 : {lw | bs | ds, lw | bs | ds, ds, (lw | bs) & ~ds, ds, idle & dv, ds, doneNow};
        expQ.push_back(e);
        #1;
        check(tag, {24'h0, stallF, stallD, stallE, flushE, flushM, div_start, div_busy, div_done}, {24'h0, expQ.pop_front()});
        if (trackDone && div_done) doneCyc.push_back(cyc);
        @(posedge clk);
        cyc++;
        if (r) begin
            busyLeft = 0;
            doneNow = 0;
        end else if (doneNow) doneNow = 0;
        else if (busyLeft > 0) begin
            busyLeft--;
            if (busyLeft == 0) doneNow = 1;
        end else if (dv) busyLeft = DC;
    endtask

    task automatic idleStep(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("reset1", 1, 8, 0, 8, 0, 0, 0, 1, 0, 0, 0);
        idleStep("idle");
        step("loaduse", 0, 8, 0, 8, 0, 0, 0, 1, 0, 0, 0);
        idleStep("loaduse_after");
        step("loaduse_rt0", 0, 8, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step("loaduse_rtD", 0, 3, 7, 7, 0, 0, 0, 1, 0, 0, 0);
        step("br_ex", 0, 9, 0, 0, 9, 0, 1, 0, 0, 1, 0);
        step("br_mem", 0, 9, 0, 0, 0, 9, 0, 0, 1, 1, 0);
        step("br_zero", 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
        step("br_nobranch", 0, 9, 0, 0, 9, 9, 1, 0, 1, 0, 0);
        for (int i = 0; i < DC + 1; i++) step($sformatf("div_%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("div_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idleStep("div_idle");
        step("prio_start", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < DC; i++) step($sformatf("prio_busy_%0d", i), 0, 8, 0, 8, 0, 0, 0, 1, 0, 0, 1);
        step("prio_done_lw", 0, 8, 0, 8, 0, 0, 0, 1, 0, 0, 0);
        idleStep("prio_idle");
        step("rst_start", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("rst_busy1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("rst_busy2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) idleStep($sformatf("rst_after_%0d", i));
        for (int i = 0; i < DC + 1; i++) step($sformatf("rediv_%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idleStep("rediv_done");
        idleStep("rediv_idle");
        trackDone = 1;
        for (int i = 0; i < 3 * (DC + 2); i++) step($sformatf("b2b_%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        trackDone = 0;
        idleStep("b2b_end0");
        idleStep("b2b_end1");
        check("b2b_done_count", doneCyc.size(), 3);
        if (doneCyc.size() >= 2) check("b2b_gap", doneCyc[1] - doneCyc[0], DC + 2);
        for (int i = 0; i < 400; i++)
            step($sformatf("rand_%0d", i), $urandom_range(0, 49) == 0,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);
`ifdef HAZARD_STATS_EN
        step("stats_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check("stats_cycles_rst", stall_cycles, 0);
        check("stats_divs_rst", {16'h0, div_count}, 0);
`endif
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core; sits beside the forwarding unit and drives the stage stall/flush enables.
- Detects load-use hazards and ID-stage branch-compare dependencies that forwarding cannot cover.
- Sequences the multi-cycle HI/LO divider: issues its start pulse, counts its latency and holds the pipeline until the result is written.

Parameters:
- DIV_CYCLES, 32, number of BUSY cycles the divider needs after start (legal range 1..63).
- CNT_W, 6, width of the internal divider cycle counter; must satisfy 2^CNT_W > DIV_CYCLES-1.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- rsD  input  5  ID-stage rs address.
- rtD  input  5  ID-stage rt address.
- rtE  input  5  EX-stage rt address (load destination).
- writeRegAddrE  input  5  EX-stage destination register.
- writeRegAddrM  input  5  MEM-stage destination register.
- Regfile_weE  input  1  EX-stage instruction writes the regfile.
- memtoRegE  input  1  EX-stage instruction is a load.
- memtoRegM  input  1  MEM-stage instruction is a load.
- branchD  input  1  ID-stage instruction is a branch compared in ID.
- divE  input  1  EX-stage instruction is DIV/DIVU.
- stallF  output  1  hold the PC.
- stallD  output  1  hold the IF/ID register.
- stallE  output  1  hold the ID/EX register.
- flushE  output  1  insert a bubble into the ID/EX register.
- flushM  output  1  insert a bubble into the EX/MEM register.
- div_start  output  1  one-cycle start strobe to the divider.
- div_busy  output  1  divider sequence in progress.
- div_done  output  1  one-cycle strobe to write HI/LO.

Behaviour:
- Combinational hazard terms (register address 0 never matches):
  - lwstall = memtoRegE & rtE!=0 & (rtE==rsD | rtE==rtD).
  - brstall = branchD & [(Regfile_weE & writeRegAddrE!=0 & writeRegAddrE∈{rsD,rtD}) | (memtoRegM & writeRegAddrM!=0 & writeRegAddrM∈{rsD,rtD})].
- Divider FSM: states IDLE, BUSY, DONE; encoding is 2 bits; cnt is CNT_W bits.
  - IDLE: if divE, then div_start=1, cnt<=DIV_CYCLES-1, next state BUSY; otherwise stay in IDLE.
  - BUSY: if cnt==0, next state DONE; otherwise cnt<=cnt-1.
  - DONE: div_done=1, next state IDLE unconditionally. divE is not sampled in DONE, because the divide instruction leaves EX that cycle.
- Divider outputs:
  - div_stall = (IDLE & divE) | BUSY.
  - div_busy = div_stall.
  - Total pipeline hold for one divide = 1 + DIV_CYCLES cycles; div_done follows the last stall cycle.
- Stall/flush outputs:
  - stallF = stallD = lwstall | brstall | div_stall.
  - stallE = div_stall.
  - flushM = div_stall (bubble the MEM stage while EX is held).
  - flushE = (lwstall | brstall) & ~div_stall. ID/EX cannot be flushed while it is held; div_stall has priority.
- Back-to-back divides: after DONE, the next divE in IDLE restarts the sequence. There is at least one non-stall cycle between the two sequences.
- Reset:
  - rst high → state<=IDLE and cnt<=0.
  - While rst is high, all outputs are forced to 0.
  - rst asserted in BUSY aborts the sequence. No div_done is produced, and the first cycle after reset is IDLE.
- All hazard terms are purely combinational with zero latency; only the FSM and cnt are registered.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined:
  - Adds output stall_cycles [31:0], a free-running count of cycles with stallF=1.
  - Cleared by rst; saturates at 32'hFFFF_FFFF.
  - Adds output div_count [15:0], incremented on each div_done; wraps at 16'hFFFF.
- When undefined:
  - Neither port nor counter exists.
  - Functional behaviour is otherwise identical.

Decomposition:
- Shared package/defines.vh: `REG_SIZE, DIV FSM state encodings (DIV_IDLE=2'd0, DIV_BUSY=2'd1, DIV_DONE=2'd2), default DIV_CYCLES.
- One sub-module is natural: div_seq. It contains the FSM and counter and exposes div_stall/div_start/div_done.
- Hazard equations and output muxing stay in hazard_ctrl.

Test Plan:
- Load-use: memtoRegE=1, rtE=5'd8, rsD=5'd8, no divide → stallF=stallD=flushE=1 and stallE=flushM=0 for exactly that cycle. Repeat with rtE=0 → all outputs 0.
- Branch dependency: branchD=1, rsD=5'd9, Regfile_weE=1, writeRegAddrE=5'd9 → stallF=stallD=flushE=1. Then memtoRegM=1, writeRegAddrM=5'd9 with the EX match removed → still stalled.
- Divide with DIV_CYCLES=4: divE=1 in IDLE → div_start=1 that cycle; stallF/D/E=flushM=1 for 5 consecutive cycles; next cycle div_done=1 with stalls low; following cycle IDLE.
- Priority: during BUSY also drive a load-use match → flushE=0, stallE=1, stallF=1.
- Reset mid-operation: assert rst in the 2nd BUSY cycle → next cycle all outputs 0, no div_done ever pulses. A new divE after deassertion restarts the full 5-cycle stall.
- Back-to-back: divE held high across two divides → two div_done strobes separated by 1+DIV_CYCLES+1 cycles, with one non-stall cycle between sequences.
